// File: rtl/packer_mlane_if.sv
// packer_mlane_if
//   Bundles the control, beat-source and packed-output signals of packer_mlane.
//   slave  : the packer's view (control/beat inputs in, status/packed word out).
//   master : the driver's view (sequencer, beat source and consumer combined).
// Signals:
//   Sta, Bypass, NumPacker, Order   packet start and its per-packet options
//   Busy                            packer not idle
//   ReqDat / ValDat / Dat           beat request and fixed-latency beat return
//   PkVld / PkRdy                   packed-word valid/ready handshake
//   PkZero, DatPacker               packet came from bypass; packed word
interface packer_mlane_if #(
   parameter int NUM_DATA   = 32,
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 4,
   parameter int CNT_W      = $clog2(NUM_DATA)
);
   logic                           Sta;
   logic                           Bypass;
   logic [CNT_W-1:0]               NumPacker;
   logic                           Order;
   logic                           Busy;
   logic                           ReqDat;
   logic                           ValDat;
   logic [DATA_WIDTH*LANES-1:0]    Dat;
   logic                           PkVld;
   logic                           PkRdy;
   logic                           PkZero;
   logic [DATA_WIDTH*NUM_DATA-1:0] DatPacker;

   modport slave (
      input  Sta, Bypass, NumPacker, Order, ValDat, Dat, PkRdy,
      output Busy, ReqDat, PkVld, PkZero, DatPacker
   );

   modport master (
      output Sta, Bypass, NumPacker, Order, ValDat, Dat, PkRdy,
      input  Busy, ReqDat, PkVld, PkZero, DatPacker
   );
endinterface

// File: rtl/packer_mlane.sv
// packer_mlane
//   Gathers NumPacker+1 data arriving LANES per beat from a fixed-latency source
//   and assembles them into one NUM_DATA-slot word, presented on a valid/ready
//   output that holds under backpressure. Supports MSB-first or slot-0-first
//   placement and an all-zero bypass packet.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    packer_mlane_if.slave (control, beat source, packed output)
//
// state | meaning
// IDLE  | waiting for Sta
// REQ   | issuing ReqDat, one beat per cycle, B cycles
// WAIT  | collecting remaining beats until RcvCnt==B
// OUT   | PkVld high, word held until PkRdy
module packer_mlane #(
   parameter int NUM_DATA   = 32,
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 4,
   parameter int CNT_W      = $clog2(NUM_DATA)
) (
   input  logic            clk,
   input  logic            rst_n,
   packer_mlane_if.slave   bus
);

   // One extra bit so that N = NUM_DATA and slot arithmetic never wrap.
   localparam int CW = CNT_W + 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

   state_t                         state_q, state_d;
   logic [CW-1:0]                  n_q, n_d;
   logic [CW-1:0]                  b_q, b_d;
   logic [CW-1:0]                  req_cnt_q, req_cnt_d;
   logic [CW-1:0]                  rcv_cnt_q, rcv_cnt_d;
   logic                           order_q, order_d;
   logic                           req_q, req_d;
   logic                           zero_q, zero_d;
   logic [DATA_WIDTH*NUM_DATA-1:0] dat_q, dat_d;

   logic [CW-1:0]                  n_new;
   logic [CW-1:0]                  b_new;
   logic                           beat_take;
   logic [CW-1:0]                  lane_k    [LANES];
   logic [CW-1:0]                  lane_slot [LANES];
   logic                           lane_keep [LANES];

   assign n_new = {1'b0, bus.NumPacker} + CW'(1);
   assign b_new = (n_new + CW'(LANES - 1)) / CW'(LANES);

   // Per-lane datum index and destination slot for the beat arriving now.
   // lane_slot is only meaningful where lane_keep is set.
   always_comb begin
      for (int j = 0; j < LANES; j++) begin
         lane_k[j]    = rcv_cnt_q * CW'(LANES) + CW'(j);
         lane_keep[j] = (lane_k[j] < n_q);
         lane_slot[j] = order_q ? lane_k[j] : (n_q - CW'(1) - lane_k[j]);
      end
   end

   // Beats count only while collecting and only up to B; stray ValDat is dropped.
   assign beat_take = ((state_q == REQ) || (state_q == WAIT)) && bus.ValDat &&
                      (rcv_cnt_q < b_q);

   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      b_d       = b_q;
      req_cnt_d = req_cnt_q;
      rcv_cnt_d = rcv_cnt_q;
      order_d   = order_q;
      zero_d    = zero_q;
      dat_d     = dat_q;

      if (beat_take) begin
         rcv_cnt_d = rcv_cnt_q + CW'(1);
         for (int j = 0; j < LANES; j++) begin
            if (lane_keep[j]) begin
               dat_d[int'(lane_slot[j])*DATA_WIDTH +: DATA_WIDTH] =
                  bus.Dat[j*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end

      unique case (state_q)
         IDLE: begin
            if (bus.Sta) begin
               dat_d = '0;
               if (bus.Bypass) begin
                  zero_d  = 1'b1;
                  state_d = OUT;
               end else begin
                  zero_d    = 1'b0;
                  n_d       = n_new;
                  order_d   = bus.Order;
                  b_d       = b_new;
                  req_cnt_d = '0;
                  rcv_cnt_d = '0;
                  state_d   = REQ;
               end
            end
         end
         REQ: begin
            req_cnt_d = req_cnt_q + CW'(1);
            if (req_cnt_d == b_q) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            // Look at the updated count so the last beat moves us straight to OUT.
            if (rcv_cnt_d == b_q) begin
               state_d = OUT;
            end
         end
         OUT: begin
            if (bus.PkRdy) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      req_d = (state_d == REQ);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         n_q       <= '0;
         b_q       <= '0;
         req_cnt_q <= '0;
         rcv_cnt_q <= '0;
         order_q   <= 1'b0;
         req_q     <= 1'b0;
         zero_q    <= 1'b0;
         dat_q     <= '0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         b_q       <= b_d;
         req_cnt_q <= req_cnt_d;
         rcv_cnt_q <= rcv_cnt_d;
         order_q   <= order_d;
         req_q     <= req_d;
         zero_q    <= zero_d;
         dat_q     <= dat_d;
      end
   end

   assign bus.Busy      = (state_q != IDLE);
   assign bus.ReqDat    = req_q;
   assign bus.PkVld     = (state_q == OUT);
   assign bus.PkZero    = zero_q;
   assign bus.DatPacker = dat_q;

endmodule

// File: tb/tb_packer_mlane.sv
// tb_packer_mlane
//   Directed bench for packer_mlane (NUM_DATA=32, DATA_WIDTH=8, LANES=4).
//   A source process answers every ReqDat cycle with a beat one cycle later,
//   taken from the beats[] table loaded by each test.
module tb_packer_mlane;

   localparam int ND = 32;
   localparam int DW = 8;
   localparam int LN = 4;
   localparam int CW = 5;

   logic clk;
   logic rst_n;

   packer_mlane_if #(.NUM_DATA(ND), .DATA_WIDTH(DW), .LANES(LN), .CNT_W(CW)) bus ();

   packer_mlane #(.NUM_DATA(ND), .DATA_WIDTH(DW), .LANES(LN), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks;
   int errors;

   logic [DW*LN-1:0] beats [8];
   logic             req_prev;
   int               src_idx;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Fixed-latency source: ValDat one cycle after each ReqDat cycle.
   initial begin
      req_prev = 1'b0;
      src_idx  = 0;
      forever begin
         @(negedge clk);
         if (req_prev) begin
            if (!bus.ValDat) src_idx = 0;
            bus.ValDat = 1'b1;
            bus.Dat    = (src_idx < 8) ? beats[src_idx] : '0;
            src_idx++;
         end else begin
            bus.ValDat = 1'b0;
            bus.Dat    = '0;
         end
         req_prev = bus.ReqDat;
      end
   end

   // Called at a negedge (cycle 0): drives Sta, then watches up to max_cyc
   // cycles, returning at the negedge of the first PkVld cycle.
   task automatic run_packet(input logic [CW-1:0] np, input logic ord, input logic byp,
                             input int max_cyc, output int req_cnt, output int first_req,
                             output int vld_cyc);
      bus.Sta       = 1'b1;
      bus.Bypass    = byp;
      bus.NumPacker = np;
      bus.Order     = ord;
      req_cnt   = 0;
      first_req = -1;
      vld_cyc   = -1;
      for (int c = 1; c <= max_cyc; c++) begin
         @(negedge clk);
         if (c == 1) begin
            bus.Sta    = 1'b0;
            bus.Bypass = 1'b0;
         end
         if (bus.ReqDat) begin
            req_cnt++;
            if (first_req < 0) first_req = c;
         end
         if (bus.PkVld) begin
            vld_cyc = c;
            break;
         end
      end
   endtask

   task automatic test_reset();
      checks++;
      if (bus.Busy !== 1'b0 || bus.ReqDat !== 1'b0 || bus.PkVld !== 1'b0 || bus.PkZero !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags got busy=%b req=%b vld=%b zero=%b want all 0",
                  bus.Busy, bus.ReqDat, bus.PkVld, bus.PkZero);
      end
      checks++;
      if (bus.DatPacker !== '0) begin
         errors++;
         $display("FAIL reset_data got %h want 0", bus.DatPacker);
      end
   endtask

   task automatic test_order0();
      int rc, fr, vc;
      logic [DW*ND-1:0] exp;
      beats[0] = 32'h04030201;
      beats[1] = 32'h08070605;
      exp = '0;
      exp[63:0] = 64'h0102030405060708;
      run_packet(5'd7, 1'b0, 1'b0, 20, rc, fr, vc);
      checks++;
      if (rc !== 2 || fr !== 1 || vc !== 4) begin
         errors++;
         $display("FAIL order0_timing got req=%0d first=%0d vld=%0d want 2 1 4", rc, fr, vc);
      end
      checks++;
      if (bus.DatPacker !== exp || bus.PkZero !== 1'b0) begin
         errors++;
         $display("FAIL order0_data got %h zero=%b want %h zero=0", bus.DatPacker, bus.PkZero, exp);
      end
      bus.PkRdy = 1'b1;
      @(negedge clk);
      bus.PkRdy = 1'b0;
      checks++;
      if (bus.Busy !== 1'b0 || bus.PkVld !== 1'b0) begin
         errors++;
         $display("FAIL order0_release got busy=%b vld=%b want 0 0", bus.Busy, bus.PkVld);
      end
   endtask

   task automatic test_order1();
      int rc, fr, vc;
      logic [DW*ND-1:0] exp;
      beats[0] = 32'h44332211;
      beats[1] = 32'hBBAA6655;
      exp = '0;
      exp[47:0] = 48'h665544332211;
      run_packet(5'd5, 1'b1, 1'b0, 20, rc, fr, vc);
      checks++;
      if (rc !== 2 || vc !== 4) begin
         errors++;
         $display("FAIL order1_timing got req=%0d vld=%0d want 2 4", rc, vc);
      end
      checks++;
      if (bus.DatPacker !== exp) begin
         errors++;
         $display("FAIL order1_data got %h want %h", bus.DatPacker, exp);
      end
      bus.PkRdy = 1'b1;
      @(negedge clk);
      bus.PkRdy = 1'b0;
   endtask

   task automatic test_bypass();
      int rc, fr, vc;
      run_packet(5'd9, 1'b1, 1'b1, 10, rc, fr, vc);
      checks++;
      if (vc !== 1 || rc !== 0) begin
         errors++;
         $display("FAIL bypass_timing got vld=%0d req=%0d want 1 0", vc, rc);
      end
      checks++;
      if (bus.PkZero !== 1'b1 || bus.DatPacker !== '0) begin
         errors++;
         $display("FAIL bypass_data got zero=%b data=%h want 1 0", bus.PkZero, bus.DatPacker);
      end
      bus.PkRdy = 1'b1;
      @(negedge clk);
      bus.PkRdy = 1'b0;
      checks++;
      if (bus.PkZero !== 1'b1 || bus.Busy !== 1'b0) begin
         errors++;
         $display("FAIL bypass_after got zero=%b busy=%b want 1 0", bus.PkZero, bus.Busy);
      end
   endtask

   task automatic test_full();
      int rc, fr, vc;
      logic [DW*ND-1:0] exp;
      for (int b = 0; b < 8; b++)
         for (int j = 0; j < LN; j++)
            beats[b][j*DW +: DW] = 8'(b*LN + j + 1);
      exp = '0;
      for (int k = 0; k < ND; k++) exp[(ND-1-k)*DW +: DW] = 8'(k + 1);
      run_packet(5'd31, 1'b0, 1'b0, 30, rc, fr, vc);
      checks++;
      if (rc !== 8 || vc !== 10) begin
         errors++;
         $display("FAIL full_timing got req=%0d vld=%0d want 8 10", rc, vc);
      end
      checks++;
      if (bus.DatPacker[255:248] !== 8'h01 || bus.DatPacker[7:0] !== 8'h20) begin
         errors++;
         $display("FAIL full_ends got top=%h bot=%h want 01 20",
                  bus.DatPacker[255:248], bus.DatPacker[7:0]);
      end
      checks++;
      if (bus.DatPacker !== exp) begin
         errors++;
         $display("FAIL full_data got %h want %h", bus.DatPacker, exp);
      end
      bus.PkRdy = 1'b1;
      @(negedge clk);
      bus.PkRdy = 1'b0;
   endtask

   task automatic test_backpressure();
      int rc, fr, vc, bad;
      logic [DW*ND-1:0] exp;
      beats[0] = 32'hC4C3C2C1;
      exp = '0;
      exp[23:0] = 24'hC3C2C1;
      run_packet(5'd2, 1'b1, 1'b0, 10, rc, fr, vc);
      checks++;
      if (vc !== 3 || rc !== 1) begin
         errors++;
         $display("FAIL bp_timing got vld=%0d req=%0d want 3 1", vc, rc);
      end
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin
            bus.Sta       = 1'b1;
            bus.NumPacker = 5'd31;
            bus.Order     = 1'b0;
         end else begin
            bus.Sta = 1'b0;
         end
         @(negedge clk);
         if (bus.PkVld !== 1'b1 || bus.ReqDat !== 1'b0 || bus.DatPacker !== exp) bad++;
      end
      bus.Sta = 1'b0;
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL bp_hold got %0d bad cycles want 0 (data %h)", bad, bus.DatPacker);
      end
      bus.PkRdy = 1'b1;
      @(negedge clk);
      bus.PkRdy = 1'b0;
      checks++;
      if (bus.Busy !== 1'b0 || bus.PkVld !== 1'b0) begin
         errors++;
         $display("FAIL bp_release got busy=%b vld=%b want 0 0", bus.Busy, bus.PkVld);
      end
      // Sta in the very first idle cycle must be accepted.
      beats[0] = 32'h0000005A;
      exp = '0;
      exp[7:0] = 8'h5A;
      run_packet(5'd0, 1'b0, 1'b0, 10, rc, fr, vc);
      checks++;
      if (vc !== 3 || bus.DatPacker !== exp) begin
         errors++;
         $display("FAIL bp_next got vld=%0d data=%h want 3 %h", vc, bus.DatPacker, exp);
      end
      bus.PkRdy = 1'b1;
      @(negedge clk);
      bus.PkRdy = 1'b0;
   endtask

   task automatic test_reset_mid();
      int rc, fr, vc;
      logic [DW*ND-1:0] exp;
      for (int b = 0; b < 8; b++) beats[b] = 32'hDEADBEEF;
      exp = '0;
      exp[127:96] = 32'hEFBEADDE;
      bus.Sta       = 1'b1;
      bus.NumPacker = 5'd15;
      bus.Order     = 1'b0;
      @(negedge clk);
      bus.Sta = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus.ReqDat !== 1'b1 || bus.DatPacker !== exp) begin
         errors++;
         $display("FAIL rst_pre got req=%b data=%h want 1 %h", bus.ReqDat, bus.DatPacker, exp);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.Busy !== 1'b0 || bus.ReqDat !== 1'b0 || bus.PkVld !== 1'b0 ||
          bus.PkZero !== 1'b0 || bus.DatPacker !== '0) begin
         errors++;
         $display("FAIL rst_async got busy=%b req=%b vld=%b zero=%b data=%h want all 0",
                  bus.Busy, bus.ReqDat, bus.PkVld, bus.PkZero, bus.DatPacker);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.Busy !== 1'b0 || bus.ReqDat !== 1'b0 || bus.DatPacker !== '0) begin
         errors++;
         $display("FAIL rst_trailing got busy=%b req=%b data=%h want 0 0 0",
                  bus.Busy, bus.ReqDat, bus.DatPacker);
      end
      beats[0] = 32'hA4A3A2A1;
      exp = '0;
      exp[31:0] = 32'hA4A3A2A1;
      run_packet(5'd3, 1'b1, 1'b0, 10, rc, fr, vc);
      checks++;
      if (vc !== 3 || rc !== 1 || bus.DatPacker !== exp) begin
         errors++;
         $display("FAIL rst_next got vld=%0d req=%0d data=%h want 3 1 %h",
                  vc, rc, bus.DatPacker, exp);
      end
      bus.PkRdy = 1'b1;
      @(negedge clk);
      bus.PkRdy = 1'b0;
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst_n         = 1'b0;
      bus.Sta       = 1'b0;
      bus.Bypass    = 1'b0;
      bus.NumPacker = '0;
      bus.Order     = 1'b0;
      bus.PkRdy     = 1'b0;
      for (int b = 0; b < 8; b++) beats[b] = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_order0();
      test_order1();
      test_bypass();
      test_full();
      test_backpressure();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got no finish want finish");
      $fatal(1);
   end

endmodule

// File: doc/packer_mlane.md
# packer_mlane

Multi-lane, parametrised successor to the single-datum packer. It gathers `NumPacker+1` data of `DATA_WIDTH` bits arriving `LANES` per beat from a fixed-latency source and assembles them into one `NUM_DATA`-slot word. The word is presented on a valid/ready output with hold under backpressure. Two placement orders and a zero-packet bypass are selectable per packet; the block sits between the on-chip buffer read port and PE-array operand registers.

## Interface
- `NUM_DATA`, 32: slots in the packed word.
- `DATA_WIDTH`, 8: bits per datum.
- `LANES`, 4: data per input beat; must divide `NUM_DATA`.
- `CNT_W`, clog2(`NUM_DATA`): width of the count field.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Sta`  in  1  start pulse; honoured only when `Busy`=0.
- `Bypass`  in  1  qualifies `Sta`: emit an all-zero packet.
- `NumPacker`  in  `CNT_W`  datum count minus 1 (0..NUM_DATA-1); sampled at accepted `Sta`.
- `Order`  in  1  0 = first datum most significant; 1 = first datum in slot 0; sampled at accepted `Sta`.
- `Busy`  out  1  high whenever state ≠ IDLE.
- `ReqDat`  out  1  beat request, registered.
- `ValDat`  in  1  beat valid; exactly 1 cycle after each `ReqDat` cycle.
- `Dat`  in  `DATA_WIDTH*LANES`  beat; lane j at bits [j*DATA_WIDTH +: DATA_WIDTH].
- `PkVld`  out  1  packed word valid.
- `PkRdy`  in  1  consumer accepts when `PkVld`&`PkRdy`.
- `PkZero`  out  1  current packet came from a bypass.
- `DatPacker`  out  `DATA_WIDTH*NUM_DATA`  packed word.

## Operation
- States: IDLE, REQ, WAIT, OUT.
- IDLE, `Sta`&`Bypass`: clear `DatPacker`, set `PkZero`=1, go to OUT. No `ReqDat` is issued.
- IDLE, `Sta`&~`Bypass`: latch N=`NumPacker`+1 and `Order`, clear `DatPacker` and `PkZero`, set B=ceil(N/`LANES`), clear ReqCnt and RcvCnt, go to REQ.
- REQ: `ReqDat`=1 for exactly B consecutive cycles (ReqCnt counts to B), then go to WAIT.
- WAIT: stay until RcvCnt==B, then go to OUT. For a legal source this is one cycle.
- `ValDat` in REQ/WAIT: increment RcvCnt and write lanes. Lane j of beat b is datum k=b*`LANES`+j.
  - Data with k ≥ N are discarded.
  - Order=0: datum k goes to slot N-1-k.
  - Order=1: datum k goes to slot k.
  - Slot s occupies bits [s*DATA_WIDTH +: DATA_WIDTH]. Slots ≥ N stay 0.
- `ValDat` in IDLE or OUT, or after RcvCnt==B: ignored.
- OUT: `PkVld`=1. `DatPacker` and `PkZero` are held stable until `PkVld`&`PkRdy`, then go to IDLE.
- `Sta` while `Busy`=1: ignored entirely; the latched count and order do not change.
- `Bypass` without `Sta`: ignored.
- Slot-index arithmetic is done at `CNT_W`+1 bits so N=`NUM_DATA` does not wrap.

## Timing
- Reset values: state IDLE; `Busy`, `ReqDat`, `PkVld`, `PkZero` = 0; `DatPacker` = 0; counters = 0.
- Normal packet, `Sta` accepted at cycle 0:
  - `ReqDat` high in cycles 1..B.
  - `ValDat` in cycles 2..B+1.
  - `PkVld` rises at cycle B+2.
- Bypass packet, `Sta` at cycle 0: `PkVld`=1 at cycle 1.
- Handshake completing at cycle t: state is IDLE at t+1 and `PkVld` is low at t+1. A new `Sta` at t+1 is accepted. Minimum packet spacing is B+3 cycles.
- `DatPacker` updates only on accepted `Sta` and on counted `ValDat`. Partial contents are visible during REQ/WAIT but are defined valid only while `PkVld`=1.
- `rst_n` asserted in any state returns all state and outputs to reset values immediately. Any in-flight `ValDat` after release is ignored (state IDLE).

## Test plan
- `NUM_DATA`=32, `LANES`=4; `NumPacker`=7, `Order`=0; beats {01,02,03,04},{05,06,07,08} (lane0 first) -> `ReqDat` cycles 1-2, `PkVld` at cycle 4, `DatPacker`[63:0]=0x0102030405060708, bits [255:64]=0.
- `NumPacker`=5, `Order`=1; beats {11,22,33,44},{55,66,AA,BB} -> `DatPacker`[47:0]=0x665544332211, upper bits 0; AA and BB discarded; exactly 2 `ReqDat` cycles.
- `Sta`&`Bypass` at cycle 0 -> `PkVld`=1, `PkZero`=1, `DatPacker`=0 at cycle 1; `ReqDat` never high.
- `NumPacker`=31, `Order`=0, data k=k+1 -> 8 `ReqDat` cycles; `DatPacker`[255:248]=0x01, [7:0]=0x20.
- `PkRdy` held low 5 cycles in OUT with `Sta` pulsed -> `PkVld` and `DatPacker` unchanged, no `ReqDat`; after `PkRdy`=1, IDLE next cycle; a `Sta` then is accepted.
- `rst_n` pulsed during REQ of a `NumPacker`=15 packet -> all outputs 0 immediately; trailing `ValDat` ignored; the next packet (`NumPacker`=3, `Order`=1, {A1,A2,A3,A4}) gives `DatPacker`[31:0]=0xA4A3A2A1.
